// File: rtl/trap_sequencer.sv
// Trap/return sequencer: arbitrates exceptions, xRET and interrupts, drains the
// pipeline, issues a one-cycle CSR commit and hands the redirect target to fetch.
module trap_sequencer #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DRAIN_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    input  logic [4:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            ret_valid,
    input  logic [1:0]      ret_type,
    input  logic [XLEN-1:0] next_pc,
    input  logic            m_interrupt,
    input  logic            m_timer,
    input  logic            s_interrupt,
    input  logic            s_timer,
    input  logic            u_ext,
    input  logic            u_soft,
    input  logic            u_timer,
    input  logic            m_eie,
    input  logic            m_tie,
    input  logic            s_eie,
    input  logic            s_tie,
    input  logic            u_eie,
    input  logic            u_sie,
    input  logic            u_tie,
    input  logic            pipe_empty,
    input  logic [XLEN-1:0] epc,
    input  logic            redirect_ready,
    output logic            exc_ready,
    output logic            ret_ready,
    output logic            flush,
    output logic            exception_pending,
    output logic [XLEN-1:0] cause,
    output logic [XLEN-1:0] pc_exc,
    output logic            m_ret,
    output logic            s_ret,
    output logic            u_ret,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy,
    output logic            drain_timeout
);
    localparam int unsigned CW = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] lat_cause_q, lat_cause_d, lat_pc_q, lat_pc_d;
    logic [2:0]      lat_ret_q, lat_ret_d;
    logic [XLEN-1:0] cause_q, cause_d, pc_exc_q, pc_exc_d, redirect_pc_q, redirect_pc_d;
    logic [2:0]      ret_q, ret_d;
    logic            flush_q, flush_d, pend_q, pend_d, rv_q, rv_d;
    logic            busy_q, busy_d, dto_q, dto_d;
    logic            irq_any;
    logic [3:0]      irq_code;

    always_comb begin
        irq_any  = 1'b1;
        irq_code = 4'd0;
        if      (m_interrupt && m_eie) irq_code = 4'd11;
        else if (m_timer     && m_tie) irq_code = 4'd7;
        else if (s_interrupt && s_eie) irq_code = 4'd9;
        else if (s_timer     && s_tie) irq_code = 4'd5;
        else if (u_ext       && u_eie) irq_code = 4'd8;
        else if (u_soft      && u_sie) irq_code = 4'd0;
        else if (u_timer     && u_tie) irq_code = 4'd4;
        else                           irq_any  = 1'b0;
    end

    // Outputs are registered by decoding the next state, so they stay Moore
    // with respect to state_q while coming straight from flops.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lat_cause_d   = lat_cause_q;
        lat_pc_d      = lat_pc_q;
        lat_ret_d     = lat_ret_q;
        redirect_pc_d = redirect_pc_q;
        dto_d         = dto_q;
        unique case (state_q)
            IDLE: begin
                if (exc_valid || ret_valid || irq_any) begin
                    state_d   = DRAIN;
                    cnt_d     = '0;
                    lat_ret_d = '0;
                    if (exc_valid) begin
                        lat_cause_d = {{(XLEN-5){1'b0}}, exc_code};
                        lat_pc_d    = exc_pc;
                    end else if (ret_valid) begin
                        lat_cause_d = '0;
                        lat_pc_d    = '0;
                        unique case (ret_type)
                            2'b11: lat_ret_d = 3'b100;
                            2'b01: lat_ret_d = 3'b010;
                            2'b00: lat_ret_d = 3'b001;
                            default: begin
                                lat_cause_d = XLEN'(2);
                                lat_pc_d    = next_pc;
                            end
                        endcase
                    end else begin
                        lat_cause_d = {1'b1, {(XLEN-5){1'b0}}, irq_code};
                        lat_pc_d    = next_pc;
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty || cnt_q == CW'(DRAIN_MAX)) begin
                    state_d = COMMIT;
                    if (!pipe_empty) dto_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            COMMIT: begin
                redirect_pc_d = epc;
                state_d       = REDIRECT;
            end
            REDIRECT: if (redirect_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        flush_d  = (state_d == DRAIN) && (cnt_d == '0);
        pend_d   = (state_d == COMMIT);
        cause_d  = pend_d ? lat_cause_d : '0;
        pc_exc_d = pend_d ? lat_pc_d : '0;
        ret_d    = pend_d ? lat_ret_d : '0;
        rv_d     = (state_d == REDIRECT);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            lat_cause_q   <= '0;
            lat_pc_q      <= '0;
            lat_ret_q     <= '0;
            redirect_pc_q <= '0;
            cause_q       <= '0;
            pc_exc_q      <= '0;
            ret_q         <= '0;
            flush_q       <= 1'b0;
            pend_q        <= 1'b0;
            rv_q          <= 1'b0;
            busy_q        <= 1'b0;
            dto_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lat_cause_q   <= lat_cause_d;
            lat_pc_q      <= lat_pc_d;
            lat_ret_q     <= lat_ret_d;
            redirect_pc_q <= redirect_pc_d;
            cause_q       <= cause_d;
            pc_exc_q      <= pc_exc_d;
            ret_q         <= ret_d;
            flush_q       <= flush_d;
            pend_q        <= pend_d;
            rv_q          <= rv_d;
            busy_q        <= busy_d;
            dto_q         <= dto_d;
        end
    end

    assign exc_ready         = (state_q == IDLE);
    assign ret_ready         = (state_q == IDLE) && !exc_valid;
    assign flush             = flush_q;
    assign exception_pending = pend_q;
    assign cause             = cause_q;
    assign pc_exc            = pc_exc_q;
    assign m_ret             = ret_q[2];
    assign s_ret             = ret_q[1];
    assign u_ret             = ret_q[0];
    assign redirect_valid    = rv_q;
    assign redirect_pc       = redirect_pc_q;
    assign busy              = busy_q;
    assign drain_timeout     = dto_q;
endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer; expected values are hand-derived.
module tb_trap_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid, ret_valid, pipe_empty, redirect_ready;
    logic [4:0]  exc_code;
    logic [1:0]  ret_type;
    logic [31:0] exc_pc, next_pc, epc;
    logic        m_interrupt, m_timer, s_interrupt, s_timer, u_ext, u_soft, u_timer;
    logic        m_eie, m_tie, s_eie, s_tie, u_eie, u_sie, u_tie;
    logic        exc_ready, ret_ready, flush, exception_pending;
    logic [31:0] cause, pc_exc, redirect_pc;
    logic        m_ret, s_ret, u_ret, redirect_valid, busy, drain_timeout;

    int unsigned checks = 0;
    int unsigned errors = 0;

    trap_sequencer #(.XLEN(32), .DRAIN_MAX(15)) dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .ret_valid(ret_valid), .ret_type(ret_type), .next_pc(next_pc),
        .m_interrupt(m_interrupt), .m_timer(m_timer), .s_interrupt(s_interrupt),
        .s_timer(s_timer), .u_ext(u_ext), .u_soft(u_soft), .u_timer(u_timer),
        .m_eie(m_eie), .m_tie(m_tie), .s_eie(s_eie), .s_tie(s_tie),
        .u_eie(u_eie), .u_sie(u_sie), .u_tie(u_tie),
        .pipe_empty(pipe_empty), .epc(epc), .redirect_ready(redirect_ready),
        .exc_ready(exc_ready), .ret_ready(ret_ready), .flush(flush),
        .exception_pending(exception_pending), .cause(cause), .pc_exc(pc_exc),
        .m_ret(m_ret), .s_ret(s_ret), .u_ret(u_ret),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .drain_timeout(drain_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow a further #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_irqs();
        {m_interrupt, m_timer, s_interrupt, s_timer, u_ext, u_soft, u_timer} = '0;
        {m_eie, m_tie, s_eie, s_tie, u_eie, u_sie, u_tie} = '0;
    endtask

    int n;

    initial begin
        rst = 1'b1;
        exc_valid = 0; ret_valid = 0; exc_code = '0; ret_type = '0;
        exc_pc = '0; next_pc = '0; epc = '0; pipe_empty = 1'b1; redirect_ready = 1'b1;
        clear_irqs();
        #1;
        check_eq("rst_exc_ready", exc_ready, 1);
        check_eq("rst_ret_ready", ret_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_flush", flush, 0);
        check_eq("rst_pend", exception_pending, 0);
        check_eq("rst_rv", redirect_valid, 0);
        check_eq("rst_rpc", redirect_pc, 0);
        check_eq("rst_dto", drain_timeout, 0);
        tick(); tick();
        rst = 1'b0;

        // Basic exception, minimum latency
        exc_valid = 1; exc_code = 5'd2; exc_pc = 32'h100; epc = 32'h80;
        #1;
        check_eq("exc_ready_c0", exc_ready, 1);
        check_eq("ret_ready_c0", ret_ready, 0);
        tick(); exc_valid = 0; #1;
        check_eq("c1_flush", flush, 1);
        check_eq("c1_busy", busy, 1);
        check_eq("c1_pend", exception_pending, 0);
        tick(); #1;
        check_eq("c2_pend", exception_pending, 1);
        check_eq("c2_cause", cause, 32'h2);
        check_eq("c2_pc", pc_exc, 32'h100);
        check_eq("c2_flush", flush, 0);
        check_eq("c2_rets", {m_ret, s_ret, u_ret}, 0);
        tick(); #1;
        check_eq("c3_rv", redirect_valid, 1);
        check_eq("c3_rpc", redirect_pc, 32'h80);
        check_eq("c3_cause_zero", cause, 0);
        tick(); #1;
        check_eq("c4_busy", busy, 0);
        check_eq("c4_rv", redirect_valid, 0);

        // Exception beats MRET beats interrupt; MRET follows
        exc_valid = 1; exc_code = 5'd3; exc_pc = 32'h300;
        ret_valid = 1; ret_type = 2'b11; m_interrupt = 1; m_eie = 1;
        #1;
        check_eq("prio_ret_ready", ret_ready, 0);
        tick(); exc_valid = 0; #1;
        tick(); #1;
        check_eq("prio_cause", cause, 32'h3);
        check_eq("prio_mret0", m_ret, 0);
        tick(); #1;
        tick(); #1;
        check_eq("prio_ret_ready_idle", ret_ready, 1);
        tick(); ret_valid = 0; clear_irqs(); #1;
        check_eq("mret_drain", flush, 1);
        tick(); #1;
        check_eq("mret_pend", exception_pending, 1);
        check_eq("mret_strobes", {m_ret, s_ret, u_ret}, 3'b100);
        check_eq("mret_cause", cause, 0);
        check_eq("mret_pc", pc_exc, 0);
        tick(); tick(); #1;

        // Interrupt priority: MTI over SEI and UEI
        s_interrupt = 1; s_eie = 1; m_timer = 1; m_tie = 1; u_ext = 1; u_eie = 1;
        next_pc = 32'h200;
        tick(); clear_irqs(); #1;
        tick(); #1;
        check_eq("irq_cause", cause, 32'h8000_0007);
        check_eq("irq_pc", pc_exc, 32'h200);
        tick(); tick(); #1;

        // SRET strobe
        ret_valid = 1; ret_type = 2'b01;
        tick(); ret_valid = 0; #1;
        tick(); #1;
        check_eq("sret_strobes", {m_ret, s_ret, u_ret}, 3'b010);
        tick(); tick(); #1;

        // Drain timeout
        pipe_empty = 0; exc_valid = 1; exc_code = 5'd5; exc_pc = 32'h400;
        tick(); exc_valid = 0; #1;
        n = 0;
        while (!exception_pending && n < 40) begin
            n++;
            tick(); #1;
        end
        check_eq("drain_cycles", n, 16);
        check_eq("drain_timeout", drain_timeout, 1);
        check_eq("to_cause", cause, 32'h5);
        pipe_empty = 1;
        tick(); tick(); #1;

        // Redirect back-pressure
        redirect_ready = 0; exc_valid = 1; exc_code = 5'd1; exc_pc = 32'h500; epc = 32'h90;
        tick(); exc_valid = 0; #1;
        tick(); #1;
        check_eq("bp_pend", exception_pending, 1);
        tick(); epc = 32'hDEAD; #1;
        exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h600;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_rv", redirect_valid, 1);
            check_eq("bp_rpc", redirect_pc, 32'h90);
            check_eq("bp_exc_ready", exc_ready, 0);
            tick();
        end
        redirect_ready = 1;
        tick(); #1;
        check_eq("bp_idle_busy", busy, 0);
        check_eq("bp_idle_exc_ready", exc_ready, 1);
        check_eq("dto_sticky", drain_timeout, 1);
        tick(); exc_valid = 0; #1;
        tick(); #1;
        check_eq("b2b_cause", cause, 32'h4);
        check_eq("b2b_pc", pc_exc, 32'h600);
        tick(); #1;
        check_eq("b2b_rpc", redirect_pc, 32'hDEAD);
        tick(); #1;

        // Reset mid-DRAIN
        pipe_empty = 0; exc_valid = 1; exc_code = 5'd7;
        tick(); exc_valid = 0; #1;
        tick(); #1;
        check_eq("mid_busy_pre", busy, 1);
        rst = 1; #1;
        check_eq("mid_busy", busy, 0);
        check_eq("mid_flush", flush, 0);
        check_eq("mid_pend", exception_pending, 0);
        check_eq("mid_rv", redirect_valid, 0);
        check_eq("mid_dto", drain_timeout, 0);
        check_eq("mid_exc_ready", exc_ready, 1);
        tick(); rst = 0; pipe_empty = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check_eq("mid_no_commit", exception_pending, 0);
            check_eq("mid_idle", busy, 0);
        end

        // Reserved ret_type acts as illegal instruction
        ret_valid = 1; ret_type = 2'b10; next_pc = 32'h700;
        tick(); ret_valid = 0; #1;
        tick(); #1;
        check_eq("rsv_pend", exception_pending, 1);
        check_eq("rsv_cause", cause, 32'h2);
        check_eq("rsv_pc", pc_exc, 32'h700);
        check_eq("rsv_strobes", {m_ret, s_ret, u_ret}, 0);
        tick(); tick(); #1;
        check_eq("rsv_done", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
